dmem_arbiter: RTL and testbench

- Two-requester arbiter and sequencer in front of the 128-byte, byte-addressed, little-endian data memory.
- Port 0 is the CPU MEM stage. Port 1 is the debug/DMA loader.
- Accepts word requests, picks one per access slot by round-robin, and drives the memory's address, data, read and write controls for exactly one cycle.
- Returns a registered read-data/done response and rejects misaligned or out-of-range addresses without touching memory.

---
 rtl/dmem_arbiter_if.sv | 47 ++++
 rtl/dmem_arbiter.sv | 130 +++++++++++++
 tb/tb_dmem_arbiter.sv | 288 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dmem_arbiter_if.sv
// Bundle of the two requester ports and the data-memory bus seen by dmem_arbiter.
// The slave modport is the arbiter side; master is the requesters plus memory.
interface dmem_arbiter_if #(
  parameter int ADDR_W = 32
);
  logic              req0_i;
  logic              we0_i;
  logic [ADDR_W-1:0] addr0_i;
  logic [31:0]       wdata0_i;
  logic              gnt0_o;
  logic              done0_o;
  logic              err0_o;
  logic [31:0]       rdata0_o;

  logic              req1_i;
  logic              we1_i;
  logic [ADDR_W-1:0] addr1_i;
  logic [31:0]       wdata1_i;
  logic              gnt1_o;
  logic              done1_o;
  logic              err1_o;
  logic [31:0]       rdata1_o;

  logic [ADDR_W-1:0] mem_addr_o;
  logic [31:0]       mem_data_o;
  logic              mem_read_o;
  logic              mem_write_o;
  logic [31:0]       mem_data_i;

  modport slave (
    input  req0_i, we0_i, addr0_i, wdata0_i,
    output gnt0_o, done0_o, err0_o, rdata0_o,
    input  req1_i, we1_i, addr1_i, wdata1_i,
    output gnt1_o, done1_o, err1_o, rdata1_o,
    output mem_addr_o, mem_data_o, mem_read_o, mem_write_o,
    input  mem_data_i
  );

  modport master (
    output req0_i, we0_i, addr0_i, wdata0_i,
    input  gnt0_o, done0_o, err0_o, rdata0_o,
    output req1_i, we1_i, addr1_i, wdata1_i,
    input  gnt1_o, done1_o, err1_o, rdata1_o,
    input  mem_addr_o, mem_data_o, mem_read_o, mem_write_o,
    output mem_data_i
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Two-port round-robin arbiter/sequencer for the word-accessed data memory:
// one-cycle ACCESS slot per grant, registered done/err/rdata response per port.
module dmem_arbiter #(
  parameter int MEM_BYTES = 128,
  parameter int ADDR_W    = 32
) (
  input  logic           clk_i,
  input  logic           rst_i,
  dmem_arbiter_if.slave  bus
);
  typedef enum logic {IDLE, ACCESS} state_t;

  localparam logic [ADDR_W-1:0] MAX_ADDR = ADDR_W'(MEM_BYTES - 4);

  state_t            state_reg, state_next;
  logic              sel_reg, sel_next;
  logic              last_reg, last_next;
  logic              cmd_we_reg, cmd_we_next;
  logic              cmd_err_reg, cmd_err_next;
  logic [ADDR_W-1:0] cmd_addr_reg, cmd_addr_next;
  logic [31:0]       cmd_wdata_reg, cmd_wdata_next;

  logic [1:0]        req;
  logic [1:0]        we;
  logic [1:0]        elig;
  logic [1:0]        hit;
  logic [ADDR_W-1:0] addr [2];
  logic [31:0]       wdata [2];
  logic              win_valid;
  logic              win;

  assign req      = {bus.req1_i, bus.req0_i};
  assign we       = {bus.we1_i, bus.we0_i};
  assign addr[0]  = bus.addr0_i;
  assign addr[1]  = bus.addr1_i;
  assign wdata[0] = bus.wdata0_i;
  assign wdata[1] = bus.wdata1_i;

  // The port whose ACCESS cycle is ending cannot win the same edge.
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_elig
      assign hit[gi]  = (state_reg == ACCESS) && (sel_reg == 1'(gi));
      assign elig[gi] = req[gi] && !hit[gi];
    end
  endgenerate

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_reg     <= IDLE;
      sel_reg       <= 1'b0;
      last_reg      <= 1'b1;
      cmd_we_reg    <= 1'b0;
      cmd_err_reg   <= 1'b0;
      cmd_addr_reg  <= '0;
      cmd_wdata_reg <= '0;
    end else begin
      state_reg     <= state_next;
      sel_reg       <= sel_next;
      last_reg      <= last_next;
      cmd_we_reg    <= cmd_we_next;
      cmd_err_reg   <= cmd_err_next;
      cmd_addr_reg  <= cmd_addr_next;
      cmd_wdata_reg <= cmd_wdata_next;
    end
  end

  always_comb begin
    state_next     = IDLE;
    sel_next       = sel_reg;
    last_next      = last_reg;
    cmd_we_next    = cmd_we_reg;
    cmd_err_next   = cmd_err_reg;
    cmd_addr_next  = cmd_addr_reg;
    cmd_wdata_next = cmd_wdata_reg;
    win_valid      = |elig;
    win            = (elig == 2'b11) ? ~last_reg : elig[1];

    // IDLE and the end of ACCESS arbitrate identically; only the mask differs.
    case (state_reg)
      IDLE, ACCESS: begin
        if (win_valid) begin
          state_next     = ACCESS;
          sel_next       = win;
          last_next      = win;
          cmd_we_next    = we[win];
          cmd_addr_next  = addr[win];
          cmd_wdata_next = wdata[win];
          cmd_err_next   = (addr[win][1:0] != 2'b00) || (addr[win] > MAX_ADDR);
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign bus.gnt0_o      = hit[0];
  assign bus.gnt1_o      = hit[1];
  assign bus.mem_addr_o  = cmd_addr_reg;
  assign bus.mem_data_o  = cmd_wdata_reg;
  assign bus.mem_write_o = (state_reg == ACCESS) && !cmd_err_reg && cmd_we_reg;
  assign bus.mem_read_o  = (state_reg == ACCESS) && !cmd_err_reg && !cmd_we_reg;

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_resp
      logic        done_reg;
      logic        err_reg;
      logic [31:0] rdata_reg;

      always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
          done_reg  <= 1'b0;
          err_reg   <= 1'b0;
          rdata_reg <= '0;
        end else begin
          done_reg <= hit[gi];
          err_reg  <= hit[gi] && cmd_err_reg;
          if (hit[gi]) begin
            rdata_reg <= (!cmd_we_reg && !cmd_err_reg) ? bus.mem_data_i : 32'h0;
          end
        end
      end
    end
  endgenerate

  assign bus.done0_o  = g_resp[0].done_reg;
  assign bus.err0_o   = g_resp[0].err_reg;
  assign bus.rdata0_o = g_resp[0].rdata_reg;
  assign bus.done1_o  = g_resp[1].done_reg;
  assign bus.err1_o   = g_resp[1].err_reg;
  assign bus.rdata1_o = g_resp[1].rdata_reg;
endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: word-level reference memory predicts each
// response at issue time; a negedge monitor checks grant cycles and responses.
module tb_dmem_arbiter;
  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        err;
    logic [31:0] rdata;
  } txn_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  dmem_arbiter_if #(.ADDR_W(32)) bus ();

  dmem_arbiter #(.MEM_BYTES(128), .ADDR_W(32)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  // Byte-wide little-endian memory attached to the arbiter's bus
  logic [7:0] mem [128];
  logic       mem_clear = 1'b1;
  logic [6:0] rd_base;

  always_comb begin
    rd_base        = {bus.mem_addr_o[6:2], 2'b00};
    bus.mem_data_i = 32'h0;
    if (bus.mem_addr_o < 32'd128)
      bus.mem_data_i = {mem[rd_base + 7'd3], mem[rd_base + 7'd2], mem[rd_base + 7'd1], mem[rd_base]};
  end

  always @(posedge clk) begin
    if (mem_clear) begin
      for (int i = 0; i < 128; i++) mem[i] <= 8'h0;
    end else if (bus.mem_write_o && bus.mem_addr_o < 32'd128) begin
      for (int b = 0; b < 4; b++)
        mem[{bus.mem_addr_o[6:2], 2'b00} + 7'(b)] <= bus.mem_data_o[8*b +: 8];
    end
  end

  function automatic logic [31:0] mem_word(input int w);
    return {mem[4*w+3], mem[4*w+2], mem[4*w+1], mem[4*w]};
  endfunction

  // Reference model: a plain array of 32 words
  logic [31:0] ref_mem [32];
  txn_t        q0[$];
  txn_t        q1[$];
  logic [1:0]  pend = 2'b00;
  logic        mon_en = 1'b0;
  logic        rec_alt = 1'b0;
  int          alt_log[$];
  int          n_checks = 0;
  int          n_pass = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  task automatic push_exp(input int p, input logic we, input logic [31:0] addr, input logic [31:0] wdata);
    txn_t t;
    t.we    = we;
    t.addr  = addr;
    t.wdata = wdata;
    t.err   = (addr % 4 != 0) || (addr > 32'd124);
    t.rdata = (!we && !t.err) ? ref_mem[addr / 4] : 32'h0;
    if (we && !t.err) ref_mem[addr / 4] = wdata;
    if (p == 0) q0.push_back(t);
    else q1.push_back(t);
  endtask

  task automatic set_port(input int p, input logic req, input logic we, input logic [31:0] addr, input logic [31:0] wdata);
    if (p == 0) begin
      bus.req0_i = req; bus.we0_i = we; bus.addr0_i = addr; bus.wdata0_i = wdata;
    end else begin
      bus.req1_i = req; bus.we1_i = we; bus.addr1_i = addr; bus.wdata1_i = wdata;
    end
  endtask

  // Called just after a rising edge; returns how many edges until the grant.
  task automatic run_req(input int p, input logic we, input logic [31:0] addr, input logic [31:0] wdata, output int waited);
    logic g;
    waited = -1;
    set_port(p, 1'b1, we, addr, wdata);
    for (int n = 1; n <= 50; n++) begin
      @(posedge clk); #1;
      g = (p == 0) ? bus.gnt0_o : bus.gnt1_o;
      if (g) begin
        waited = n;
        break;
      end
    end
    if (waited < 0) begin
      n_checks++;
      $display("FAIL grant_timeout port%0d: got no gnt expected gnt within 50 cycles", p);
    end
    set_port(p, 1'b0, we, addr, wdata);
  endtask

  task automatic check_port(input int p, input logic gnt, input logic done, input logic err, input logic [31:0] rdata);
    txn_t t;
    if (pend[p]) begin
      pend[p] = 1'b0;
      chk($sformatf("done%0d_after_gnt", p), done, 1);
      if (done) begin
        if (p == 0) t = q0.pop_front();
        else t = q1.pop_front();
        chk($sformatf("err%0d@%h", p, t.addr), err, t.err);
        chk($sformatf("rdata%0d@%h", p, t.addr), rdata, t.rdata);
      end
    end else if (done) begin
      chk($sformatf("done%0d_unexpected", p), done, 0);
    end
    if (gnt) begin
      if ((p == 0 && q0.size() == 0) || (p == 1 && q1.size() == 0)) begin
        chk($sformatf("gnt%0d_unexpected", p), gnt, 0);
      end else begin
        t = (p == 0) ? q0[0] : q1[0];
        chk($sformatf("mem_addr_gnt%0d", p), bus.mem_addr_o, t.addr);
        chk($sformatf("mem_data_gnt%0d", p), bus.mem_data_o, t.wdata);
        chk($sformatf("mem_write_gnt%0d@%h", p, t.addr), bus.mem_write_o, t.we && !t.err);
        chk($sformatf("mem_read_gnt%0d@%h", p, t.addr), bus.mem_read_o, !t.we && !t.err);
        pend[p] = 1'b1;
      end
    end
  endtask

  always @(negedge clk) begin
    if (rec_alt) alt_log.push_back(bus.gnt0_o ? 0 : (bus.gnt1_o ? 1 : 2));
    if (mon_en) begin
      check_port(0, bus.gnt0_o, bus.done0_o, bus.err0_o, bus.rdata0_o);
      check_port(1, bus.gnt1_o, bus.done1_o, bus.err1_o, bus.rdata1_o);
      if (bus.mem_read_o || bus.mem_write_o)
        chk("enable_legal", (bus.gnt0_o || bus.gnt1_o) && bus.mem_addr_o[1:0] == 2'b00
                            && bus.mem_addr_o <= 32'd124, 1);
    end
  end

  task automatic rand_port(input int p, input int n, input int max_gap);
    logic [31:0] a;
    logic        we;
    logic [31:0] wd;
    int          r;
    int          w;
    for (int k = 0; k < n; k++) begin
      repeat ($urandom_range(0, max_gap)) begin @(posedge clk); #1; end
      r  = $urandom_range(0, 9);
      we = 1'($urandom_range(0, 1));
      wd = $urandom;
      if (r == 0) a = {25'd0, 5'($urandom_range(0, 31)), 2'($urandom_range(1, 3))};
      else if (r == 1) a = 32'd128 + 32'($urandom_range(0, 63)) * 4;
      else a = {25'd0, 5'(p * 16 + $urandom_range(0, 15)), 2'b00};
      push_exp(p, we, a, wd);
      run_req(p, we, a, wd, w);
    end
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_gnt"},   {bus.gnt1_o, bus.gnt0_o}, 0);
    chk({tag, "_done"},  {bus.done1_o, bus.done0_o}, 0);
    chk({tag, "_err"},   {bus.err1_o, bus.err0_o}, 0);
    chk({tag, "_rdata0"}, bus.rdata0_o, 0);
    chk({tag, "_rdata1"}, bus.rdata1_o, 0);
    chk({tag, "_en"},    {bus.mem_read_o, bus.mem_write_o}, 0);
    chk({tag, "_maddr"}, bus.mem_addr_o, 0);
    chk({tag, "_mdata"}, bus.mem_data_o, 0);
  endtask

  initial begin
    #20_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int w, w0, w1, first;
    for (int i = 0; i < 32; i++) ref_mem[i] = 32'h0;
    set_port(0, 1'b0, 1'b0, 32'h0, 32'h0);
    set_port(1, 1'b0, 1'b0, 32'h0, 32'h0);

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check_idle_outputs("reset");
    rst = 1'b0;
    mem_clear = 1'b0;
    idle_cycles(1);
    check_idle_outputs("post_reset");
    mon_en = 1'b1;

    // Port 0 write, then port 1 reads it back
    push_exp(0, 1'b1, 32'h10, 32'hDEADBEEF);
    run_req(0, 1'b1, 32'h10, 32'hDEADBEEF, w);
    chk("gnt0_latency", w, 1);
    idle_cycles(2);
    chk("mem_word4", mem_word(4), 32'hDEADBEEF);
    push_exp(1, 1'b0, 32'h10, 32'h0BADF00D);
    run_req(1, 1'b0, 32'h10, 32'h0BADF00D, w);
    idle_cycles(2);

    // Misaligned, out-of-range, and the last legal word
    push_exp(0, 1'b0, 32'h12, 32'h1);
    run_req(0, 1'b0, 32'h12, 32'h1, w);
    push_exp(0, 1'b0, 32'h7E, 32'h2);
    run_req(0, 1'b0, 32'h7E, 32'h2, w);
    push_exp(0, 1'b0, 32'h7C, 32'h3);
    run_req(0, 1'b0, 32'h7C, 32'h3, w);
    idle_cycles(2);

    // Same-cycle write/read of one address with last=1: port 0 goes first
    push_exp(1, 1'b0, 32'h44, 32'h0);
    run_req(1, 1'b0, 32'h44, 32'h0, w);
    idle_cycles(2);
    push_exp(0, 1'b1, 32'h20, 32'hCAFE1234);
    push_exp(1, 1'b0, 32'h20, 32'h0);
    fork
      run_req(0, 1'b1, 32'h20, 32'hCAFE1234, w0);
      run_req(1, 1'b0, 32'h20, 32'h0, w1);
    join
    chk("tie_order_p0", w0, 1);
    chk("tie_order_p1", w1, 2);
    idle_cycles(3);

    // Reset in the middle of a port 1 write ACCESS cycle
    mon_en = 1'b0;
    mem_clear = 1'b1;
    idle_cycles(1);
    mem_clear = 1'b0;
    for (int i = 0; i < 32; i++) ref_mem[i] = 32'h0;
    set_port(1, 1'b1, 1'b1, 32'h40, 32'h12345678);
    idle_cycles(1);
    chk("rst_mid_gnt1", bus.gnt1_o, 1);
    chk("rst_mid_write_before", bus.mem_write_o, 1);
    #2 rst = 1'b1;
    #1;
    chk("rst_mid_write_after", bus.mem_write_o, 0);
    set_port(1, 1'b0, 1'b0, 32'h0, 32'h0);
    for (int k = 0; k < 2; k++) begin
      @(posedge clk); #1;
      chk("rst_mid_no_done1", bus.done1_o, 0);
    end
    chk("rst_mid_word16", mem_word(16), 32'h0);
    rst = 1'b0;
    idle_cycles(1);
    chk("rst_release_done1", bus.done1_o, 0);
    chk("rst_release_gnt", {bus.gnt1_o, bus.gnt0_o}, 0);
    mon_en = 1'b1;

    // Both ports requesting every cycle: grants alternate with no idle slots
    rec_alt = 1'b1;
    fork
      rand_port(0, 8, 0);
      rand_port(1, 8, 0);
    join
    idle_cycles(3);
    rec_alt = 1'b0;
    first = 0;
    while (first < alt_log.size() && alt_log[first] == 2) first++;
    if (alt_log.size() - first < 16) begin
      chk("alt_log_length", alt_log.size() - first, 16);
    end else begin
      for (int i = 0; i < 16; i++) chk($sformatf("alt_slot%0d", i), alt_log[first + i], i % 2);
    end

    // Randomized traffic with gaps
    fork
      rand_port(0, 40, 2);
      rand_port(1, 40, 2);
    join
    idle_cycles(5);
    chk("q0_drained", q0.size(), 0);
    chk("q1_drained", q1.size(), 0);
    chk("no_pending", pend, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
